// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and step constants for the systolic array sequencer.
//   state_t        : sequencer FSM states
//   last_read_step : last RUN step that issues an operand read (N-1)
//   first_en_step  : first RUN step that enables the array (1)
//   last_step      : final RUN step, when the corner cell does its last MAC (3N-2)
//   step_width     : bits needed for a RUN step counter that never wraps
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int last_read_step(input int n);
        return n - 1;
    endfunction

    function automatic int first_en_step();
        return 1;
    endfunction

    function automatic int last_step(input int n);
        return 3 * n - 2;
    endfunction

    // Counter holds 0..3N-2, so it needs clog2(3N-1) bits.
    function automatic int step_width(input int n);
        return $clog2(3 * n - 1);
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl_if
// Bundles the sequencer's control handshake, both operand-buffer read ports
// and the two array edge buses.
//   master : the sequencer (drives reads, array controls and edges)
//   slave  : the environment (operand buffers, array, requester)
// Optional build macro SYSTOLIC_STALL_EN adds the 1-bit stall input.
// -----------------------------------------------------------------------------
interface systolic_seq_ctrl_if #(
    parameter int N      = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(N)
);
    logic                start;
    logic                busy;
    logic                done;
    logic                array_clear;
    logic                array_en;
    logic                a_rd_en;
    logic [ADDR_W-1:0]   a_rd_addr;
    logic [N*WIDTH-1:0]  a_rd_data;
    logic                b_rd_en;
    logic [ADDR_W-1:0]   b_rd_addr;
    logic [N*WIDTH-1:0]  b_rd_data;
    logic [N*WIDTH-1:0]  edge_left;
    logic [N*WIDTH-1:0]  edge_top;
`ifdef SYSTOLIC_STALL_EN
    logic                stall;

    modport master (
        input  start, stall, a_rd_data, b_rd_data,
        output busy, done, array_clear, array_en,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               edge_left, edge_top
    );

    modport slave (
        output start, stall, a_rd_data, b_rd_data,
        input  busy, done, array_clear, array_en,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               edge_left, edge_top
    );
`else
    modport master (
        input  start, a_rd_data, b_rd_data,
        output busy, done, array_clear, array_en,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               edge_left, edge_top
    );

    modport slave (
        output start, a_rd_data, b_rd_data,
        input  busy, done, array_clear, array_en,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               edge_left, edge_top
    );
`endif
endinterface

// File: rtl/skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// DEPTH-stage register chain used to delay one operand lane so that the
// wavefront enters the array diagonally. DEPTH = 0 is a plain wire.
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears every stage
//   en    : shift enable; the chain holds when low
//   din   : lane input
//   dout  : lane input delayed by DEPTH enabled clocks
// -----------------------------------------------------------------------------
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;

        // Clock, reset and enable are meaningless for a zero-depth lane.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clock, reset, en};
    end else begin : g_regs
        logic [WIDTH-1:0] stage [DEPTH];

        // NOTE: unlike a RAM, these stages are reset: an aborted run would
        // otherwise leave live operands in flight that the next run would
        // feed into the array as nonzero MAC inputs.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int d = 0; d < DEPTH; d++) begin
                    stage[d] <= '0;
                end
            end else if (en) begin
                stage[0] <= din;
                for (int d = 1; d < DEPTH; d++) begin
                    stage[d] <= stage[d-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for an N x N output-stationary systolic MAC array. On start it
// clears the array, streams A columns / B rows from the operand buffers,
// skews lane i by i steps onto the left/top edges, enables the array for
// exactly the steps that carry a MAC, then pulses done.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : systolic_seq_ctrl_if.master
//           start (in), busy, done, array_clear, array_en (out),
//           a_rd_en/a_rd_addr (out), a_rd_data (in),
//           b_rd_en/b_rd_addr (out), b_rd_data (in),
//           edge_left, edge_top (out), stall (in, optional)
//
// Build option: define SYSTOLIC_STALL_EN to add the stall input, which
// freezes the RUN sequence (counter, skew lines, read-valid pipe) and
// suppresses array_en / rd_en while high.
// -----------------------------------------------------------------------------
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic                clock,
    input  logic                reset,
    systolic_seq_ctrl_if.master bus
);

    localparam int STEP_W = step_width(N);
    localparam logic [STEP_W-1:0] LAST_READ = STEP_W'(last_read_step(N));
    localparam logic [STEP_W-1:0] FIRST_EN  = STEP_W'(first_en_step());
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(last_step(N));

    state_t             state;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_nxt;
    logic               busy_q;
    logic               done_q;
    logic               clear_q;
    logic               en_q;
    logic               rd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rd_valid;
    logic               stall_w;
    logic               advance;
    logic [N*WIDTH-1:0] a_masked;
    logic [N*WIDTH-1:0] b_masked;
    logic [N*WIDTH-1:0] edge_left_w;
    logic [N*WIDTH-1:0] edge_top_w;

`ifdef SYSTOLIC_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    // Stall only has meaning while the RUN sequence is in progress.
    assign advance  = (state == RUN) && !stall_w;
    assign step_nxt = step + 1'b1;

    // -------------------------------------------------------------------------
    // Sequencer FSM. Outputs are registered by computing, on each transition,
    // the values that belong to the step being entered.
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking ones would make the outputs depend on
    // statement order within the block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            step    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            en_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= CLEAR;
                        busy_q  <= 1'b1;
                        clear_q <= 1'b1;
                    end
                end

                CLEAR: begin
                    // Entering step 0: first operand read, array not yet fed.
                    state   <= RUN;
                    step    <= '0;
                    clear_q <= 1'b0;
                    rd_q    <= 1'b1;
                    addr_q  <= '0;
                    en_q    <= 1'b0;
                end

                RUN: begin
                    if (!stall_w) begin
                        if (step == LAST_STEP) begin
                            state  <= DONE;
                            step   <= '0;
                            done_q <= 1'b1;
                            rd_q   <= 1'b0;
                            addr_q <= '0;
                            en_q   <= 1'b0;
                        end else begin
                            step   <= step_nxt;
                            rd_q   <= (step_nxt <= LAST_READ);
                            addr_q <= (step_nxt <= LAST_READ) ? ADDR_W'(step_nxt) : '0;
                            en_q   <= (step_nxt >= FIRST_EN);
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the strobe. The valid flag holds
    // through a stall because the buffer holds its data while no read issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else if (!((state == RUN) && stall_w)) begin
            rd_valid <= rd_q && (state == RUN);
        end
    end

    // Anything the buffers present outside a valid read becomes zero, so
    // spurious MACs in the array add nothing.
    assign a_masked = bus.a_rd_data & {(N*WIDTH){rd_valid}};
    assign b_masked = bus.b_rd_data & {(N*WIDTH){rd_valid}};

    // Lane i is delayed i steps so row i / column i start i steps later.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH (i),
            .WIDTH (WIDTH)
        ) u_skew_a (
            .clock (clock),
            .reset (reset),
            .en    (advance),
            .din   (a_masked[i*WIDTH +: WIDTH]),
            .dout  (edge_left_w[i*WIDTH +: WIDTH])
        );

        skew_line #(
            .DEPTH (i),
            .WIDTH (WIDTH)
        ) u_skew_b (
            .clock (clock),
            .reset (reset),
            .en    (advance),
            .din   (b_masked[i*WIDTH +: WIDTH]),
            .dout  (edge_top_w[i*WIDTH +: WIDTH])
        );
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.array_clear = clear_q;
    assign bus.array_en    = en_q && !stall_w;
    assign bus.a_rd_en     = rd_q && !stall_w;
    assign bus.b_rd_en     = rd_q && !stall_w;
    assign bus.a_rd_addr   = addr_q;
    assign bus.b_rd_addr   = addr_q;
    assign bus.edge_left   = edge_left_w;
    assign bus.edge_top    = edge_top_w;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
// Self-checking bench: operand buffer models, a behavioural output-stationary
// MAC array driven by the sequencer, and a scoreboard of expected C matrices.
// Define SYSTOLIC_STALL_EN to include the stall scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;

    localparam int N      = 4;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = $clog2(N);
    localparam int AW     = 2 * WIDTH;
    localparam int LOGN   = 64;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    systolic_seq_ctrl_if #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    systolic_seq_ctrl #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    int unsigned a_m [N][N];
    int unsigned b_m [N][N];

    logic [AW-1:0] sb_q [$];

    // ---------------- operand buffers: 1-cycle read latency, hold otherwise
    function automatic logic [N*WIDTH-1:0] pack_a(input logic [ADDR_W-1:0] k);
        logic [N*WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(a_m[i][k]);
        return v;
    endfunction

    function automatic logic [N*WIDTH-1:0] pack_b(input logic [ADDR_W-1:0] k);
        logic [N*WIDTH-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*WIDTH +: WIDTH] = WIDTH'(b_m[k][j]);
        return v;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.a_rd_data <= '0;
            bus.b_rd_data <= '0;
        end else begin
            if (bus.a_rd_en) bus.a_rd_data <= pack_a(bus.a_rd_addr);
            if (bus.b_rd_en) bus.b_rd_data <= pack_b(bus.b_rd_addr);
        end
    end

    // ---------------- behavioural array: ar/br[i][j] feed cell j / row i
    logic [WIDTH-1:0] ar  [N][N+1];
    logic [WIDTH-1:0] br  [N+1][N];
    logic [AW-1:0]    acc [N][N];

    always @(posedge clock) begin
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        if (bus.array_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ar[i][j+1] <= '0;
                    br[i+1][j] <= '0;
                    acc[i][j]  <= '0;
                end
        end else if (bus.array_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_in = (j == 0) ? bus.edge_left[i*WIDTH +: WIDTH] : ar[i][j];
                    b_in = (i == 0) ? bus.edge_top[j*WIDTH +: WIDTH]  : br[i][j];
                    acc[i][j]  <= acc[i][j] + AW'(a_in) * AW'(b_in);
                    ar[i][j+1] <= a_in;
                    br[i+1][j] <= b_in;
                end
        end
    end

    // ---------------- per-run observation logs (index = cycle after start edge)
    logic [63:0]      busy_m, done_m, clr_m, en_m, rd_m;
    logic [ADDR_W-1:0] addr_l [LOGN];
    logic [WIDTH-1:0]  el2_l  [LOGN];
    logic [WIDTH-1:0]  et3_l  [LOGN];
    int               done_cyc;
    int               rdb_bad;

    function automatic logic [63:0] rmask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int c = lo; c <= hi; c++) m[c] = 1'b1;
        return m;
    endfunction

    function automatic void push_expected();
        int unsigned s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += a_m[i][k] * b_m[k][j];
                sb_q.push_back(AW'(s));
            end
    endfunction

    task automatic load_seq_identity();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = i * N + j + 1;
                b_m[i][j] = (i == j) ? 1 : 0;
            end
    endtask

    task automatic load_const(input int unsigned va, input int unsigned vb);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = va;
                b_m[i][j] = vb;
            end
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[i][j] = $urandom_range(0, 255);
                b_m[i][j] = $urandom_range(0, 255);
            end
    endtask

    // Issues start, then watches the DUT cycle by cycle until `jobs` done
    // pulses were seen (plus two tail cycles) or the log budget runs out.
    // At each done the scoreboard entry is popped and compared to the array.
    task automatic run_seq(input int jobs, input bit hold, input int stall_at,
                           input int stall_len, input logic [63:0] pulse_m);
        int seen;
        int tail;
        logic [AW-1:0] exp_v;
        seen = 0;
        tail = 0;
        busy_m = '0; done_m = '0; clr_m = '0; en_m = '0; rd_m = '0;
        done_cyc = 0;
        rdb_bad = 0;
        for (int c = 0; c < LOGN; c++) begin
            addr_l[c] = '0; el2_l[c] = '0; et3_l[c] = '0;
        end
        @(negedge clock);
        bus.start = 1'b1;
        for (int c = 1; c < LOGN; c++) begin
            @(negedge clock);
            bus.start = (hold && seen < jobs) || pulse_m[c];
`ifdef SYSTOLIC_STALL_EN
            bus.stall = (c >= stall_at) && (c < stall_at + stall_len);
`endif
            #1;
            busy_m[c] = bus.busy;
            done_m[c] = bus.done;
            clr_m[c]  = bus.array_clear;
            en_m[c]   = bus.array_en;
            rd_m[c]   = bus.a_rd_en;
            addr_l[c] = bus.a_rd_addr;
            el2_l[c]  = bus.edge_left[2*WIDTH +: WIDTH];
            et3_l[c]  = bus.edge_top[3*WIDTH +: WIDTH];
            if (bus.b_rd_en !== bus.a_rd_en || bus.b_rd_addr !== bus.a_rd_addr) rdb_bad++;
            if (bus.done === 1'b1) begin
                if (done_cyc == 0) done_cyc = c;
                total_cnt++;
                if (sb_q.size() < N * N) begin
                    $display("FAIL scoreboard_empty: done at cycle %0d with %0d entries queued, need %0d",
                             c, sb_q.size(), N * N);
                end else begin
                    pass_cnt++;
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) begin
                            exp_v = sb_q.pop_front();
                            total_cnt++;
                            if (acc[i][j] !== exp_v)
                                $display("FAIL c_%0d_%0d: got %0d, want %0d", i, j, acc[i][j], exp_v);
                            else
                                pass_cnt++;
                        end
                end
                seen++;
                if (seen == jobs) tail = c;
            end
            if (tail != 0 && c >= tail + 2) break;
        end
        bus.start = 1'b0;
`ifdef SYSTOLIC_STALL_EN
        bus.stall = 1'b0;
`endif
        total_cnt++;
        if (seen < jobs)
            $display("FAIL run_timeout: %0d of %0d jobs done within %0d cycles", seen, jobs, LOGN - 1);
        else
            pass_cnt++;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
`ifdef SYSTOLIC_STALL_EN
        bus.stall = 1'b0;
`endif
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({bus.busy, bus.done, bus.array_clear, bus.array_en, bus.a_rd_en, bus.b_rd_en} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, want 000000",
                     {bus.busy, bus.done, bus.array_clear, bus.array_en, bus.a_rd_en, bus.b_rd_en});
        else pass_cnt++;
        total_cnt++;
        if ({bus.a_rd_addr, bus.b_rd_addr} !== '0)
            $display("FAIL reset_addr: got %h, want 0", {bus.a_rd_addr, bus.b_rd_addr});
        else pass_cnt++;
        total_cnt++;
        if ({bus.edge_left, bus.edge_top} !== '0)
            $display("FAIL reset_edges: got %h, want 0", {bus.edge_left, bus.edge_top});
        else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b, want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [ADDR_W-1:0] exp_addr;
        load_seq_identity();
        push_expected();
        run_seq(1, 1'b0, 0, 0, '0);
        total_cnt++;
        if (done_cyc !== 3 * N + 1) $display("FAIL basic_done_cycle: got %0d, want %0d", done_cyc, 3 * N + 1);
        else pass_cnt++;
        total_cnt++;
        if (busy_m !== rmask(1, 3 * N + 1)) $display("FAIL basic_busy: got %h, want %h", busy_m, rmask(1, 3 * N + 1));
        else pass_cnt++;
        total_cnt++;
        if (done_m !== rmask(3 * N + 1, 3 * N + 1)) $display("FAIL basic_done: got %h, want %h", done_m, rmask(3 * N + 1, 3 * N + 1));
        else pass_cnt++;
        total_cnt++;
        if (clr_m !== rmask(1, 1)) $display("FAIL basic_clear: got %h, want %h", clr_m, rmask(1, 1));
        else pass_cnt++;
        total_cnt++;
        if (en_m !== rmask(3, 3 * N)) $display("FAIL basic_array_en: got %h, want %h", en_m, rmask(3, 3 * N));
        else pass_cnt++;
        total_cnt++;
        if ($countones(en_m) !== 3 * N - 2) $display("FAIL basic_en_count: got %0d, want %0d", $countones(en_m), 3 * N - 2);
        else pass_cnt++;
        total_cnt++;
        if (rd_m !== rmask(2, N + 1)) $display("FAIL basic_rd_en: got %h, want %h", rd_m, rmask(2, N + 1));
        else pass_cnt++;
        total_cnt++;
        if (rdb_bad !== 0) $display("FAIL basic_b_port: got %0d cycles differing from A port, want 0", rdb_bad);
        else pass_cnt++;
        for (int c = 1; c <= 3 * N + 3; c++) begin
            exp_addr = (c >= 2 && c <= N + 1) ? ADDR_W'(c - 2) : '0;
            total_cnt++;
            if (addr_l[c] !== exp_addr) $display("FAIL basic_addr_c%0d: got %0d, want %0d", c, addr_l[c], exp_addr);
            else pass_cnt++;
        end
    endtask

    // Uses the logs of test_basic: edge lane i carries A[i][k] at step k+1+i.
    task automatic test_skew();
        int s;
        int k;
        logic [WIDTH-1:0] exp_l;
        logic [WIDTH-1:0] exp_t;
        for (int c = 1; c <= 3 * N + 3; c++) begin
            s = c - 2;
            exp_l = '0;
            exp_t = '0;
            if (s >= 0 && s <= 3 * N - 2) begin
                k = s - 1 - 2;
                if (k >= 0 && k < N) exp_l = WIDTH'(a_m[2][k]);
                k = s - 1 - 3;
                if (k >= 0 && k < N) exp_t = WIDTH'(b_m[k][3]);
            end
            total_cnt++;
            if (el2_l[c] !== exp_l) $display("FAIL skew_left2_s%0d: got %0d, want %0d", s, el2_l[c], exp_l);
            else pass_cnt++;
            total_cnt++;
            if (et3_l[c] !== exp_t) $display("FAIL skew_top3_s%0d: got %0d, want %0d", s, et3_l[c], exp_t);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_busy;
        load_random();
        push_expected();
        push_expected();
        run_seq(2, 1'b1, 0, 0, '0);
        exp_busy = rmask(1, 3 * N + 1) | rmask(3 * N + 3, 6 * N + 3);
        total_cnt++;
        if (clr_m !== (rmask(1, 1) | rmask(3 * N + 3, 3 * N + 3)))
            $display("FAIL b2b_clear: got %h, want %h", clr_m, rmask(1, 1) | rmask(3 * N + 3, 3 * N + 3));
        else pass_cnt++;
        total_cnt++;
        if (done_m !== (rmask(3 * N + 1, 3 * N + 1) | rmask(6 * N + 3, 6 * N + 3)))
            $display("FAIL b2b_done: got %h, want %h", done_m, rmask(3 * N + 1, 3 * N + 1) | rmask(6 * N + 3, 6 * N + 3));
        else pass_cnt++;
        total_cnt++;
        if (busy_m !== exp_busy) $display("FAIL b2b_busy: got %h, want %h", busy_m, exp_busy);
        else pass_cnt++;
    endtask

    task automatic test_ignored_starts();
        logic [63:0] pulses;
        load_random();
        push_expected();
        pulses = rmask(5, 6) | rmask(3 * N + 1, 3 * N + 1);
        run_seq(1, 1'b0, 0, 0, pulses);
        total_cnt++;
        if (clr_m !== rmask(1, 1)) $display("FAIL ignore_clear: got %h, want %h", clr_m, rmask(1, 1));
        else pass_cnt++;
        total_cnt++;
        if (busy_m !== rmask(1, 3 * N + 1)) $display("FAIL ignore_busy: got %h, want %h", busy_m, rmask(1, 3 * N + 1));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        load_seq_identity();
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (6) @(negedge clock);    // cycle 7: step 5
        #1;
        total_cnt++;
        if (bus.edge_left[2*WIDTH +: WIDTH] !== WIDTH'(a_m[2][2]))
            $display("FAIL abort_pre_edge: got %0d, want %0d", bus.edge_left[2*WIDTH +: WIDTH], a_m[2][2]);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.busy, bus.done, bus.array_clear, bus.array_en, bus.a_rd_en, bus.b_rd_en} !== 6'b0)
            $display("FAIL abort_ctrl: got %b, want 000000",
                     {bus.busy, bus.done, bus.array_clear, bus.array_en, bus.a_rd_en, bus.b_rd_en});
        else pass_cnt++;
        total_cnt++;
        if ({bus.a_rd_addr, bus.b_rd_addr, bus.edge_left, bus.edge_top} !== '0)
            $display("FAIL abort_data: got %h, want 0", {bus.a_rd_addr, bus.b_rd_addr, bus.edge_left, bus.edge_top});
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load_const(3, 3);
        push_expected();
        run_seq(1, 1'b0, 0, 0, '0);
        total_cnt++;
        if (done_cyc !== 3 * N + 1) $display("FAIL abort_rerun_done: got %0d, want %0d", done_cyc, 3 * N + 1);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        load_const(255, 255);
        push_expected();
        run_seq(1, 1'b0, 0, 0, '0);
        total_cnt++;
        if (done_cyc !== 3 * N + 1) $display("FAIL ovf_done: got %0d, want %0d", done_cyc, 3 * N + 1);
        else pass_cnt++;
        total_cnt++;
        if (en_m !== rmask(3, 3 * N)) $display("FAIL ovf_array_en: got %h, want %h", en_m, rmask(3, 3 * N));
        else pass_cnt++;
    endtask

`ifdef SYSTOLIC_STALL_EN
    task automatic test_stall();
        logic [63:0] exp_en;
        load_seq_identity();
        push_expected();
        run_seq(1, 1'b0, 6, 3, '0);    // stall cycles 6..8, i.e. at step 4
        exp_en = rmask(3, 5) | rmask(9, 3 * N + 3);
        total_cnt++;
        if (done_cyc !== 3 * N + 4) $display("FAIL stall_done: got %0d, want %0d", done_cyc, 3 * N + 4);
        else pass_cnt++;
        total_cnt++;
        if (en_m !== exp_en) $display("FAIL stall_array_en: got %h, want %h", en_m, exp_en);
        else pass_cnt++;
        total_cnt++;
        if (busy_m !== rmask(1, 3 * N + 4)) $display("FAIL stall_busy: got %h, want %h", busy_m, rmask(1, 3 * N + 4));
        else pass_cnt++;
        total_cnt++;
        if (rd_m !== rmask(2, N + 1)) $display("FAIL stall_rd_en: got %h, want %h", rd_m, rmask(2, N + 1));
        else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_back_to_back();
        test_ignored_starts();
        test_reset_mid_run();
        test_overflow();
`ifdef SYSTOLIC_STALL_EN
        test_stall();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic MAC array built from the team's unit cells.
- On start, it clears the array accumulators, reads A columns and B rows from two operand buffers, and applies diagonal skew.
- It drives the array's left and top edges with zero padding and gates array clocking for exactly the needed steps, then pulses done.
- Sits between the operand SRAMs and the array; result readout of out_mem is external.

Parameters:
- N, 4, array dimension (rows = cols = K depth); N >= 2.
- WIDTH, 8, operand width; accumulators in the array are 2*WIDTH.
- ADDR_W, $clog2(N), operand buffer address width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- start  input  1  request one matrix multiply; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive
- done  output  1  one-cycle pulse in the DONE state
- array_clear  output  1  drives array reset; high only in the CLEAR state
- array_en  output  1  array step enable; array cells update only when high
- a_rd_en  output  1  A buffer read strobe
- a_rd_addr  output  ADDR_W  k index; returns column k of A, all rows packed
- a_rd_data  input  N*WIDTH  lane i = A[i][k]; valid 1 cycle after a_rd_en
- b_rd_en  output  1  B buffer read strobe, identical timing to a_rd_en
- b_rd_addr  output  ADDR_W  k index; returns row k of B
- b_rd_data  input  N*WIDTH  lane j = B[k][j]; valid 1 cycle after b_rd_en
- edge_left  output  N*WIDTH  lane i feeds the row-i left input
- edge_top  output  N*WIDTH  lane j feeds the column-j top input

Behaviour:
- Reset (async): state=IDLE, step counter=0, all skew registers=0, and every output=0 (busy, done, array_clear, array_en, rd_en, addresses, edges).
- IDLE:
  - start=1 -> CLEAR.
  - start in any other state is ignored; there is no queueing.
- CLEAR: 1 cycle, array_clear=1 -> RUN with s=0.
- RUN: step counter s runs 0..3N-2.
  - a_rd_en=b_rd_en=1 and addr=s for s in [0,N-1]; otherwise rd_en=0 and addr=0.
  - rd_valid is rd_en delayed 1 cycle. Returned data is ANDed with rd_valid, so zeros are injected outside valid reads.
  - Lane i of A data passes through a skew line of depth i, giving edge_left lane i = A[i][k] at step k+1+i.
  - Lane j of B data passes through a skew line of depth j, giving edge_top lane j = B[k][j] at step k+1+j.
  - Depth 0 is a pass-through, so edges are combinational from masked data for lane 0 only.
  - array_en=1 for s in [1,3N-2]. The last MAC, at cell (N-1,N-1) with k=N-1, occurs at s=3N-2.
  - At s=3N-2 -> DONE.
- DONE: 1 cycle, done=1, busy=1 -> IDLE. Accumulators hold C=A*B until the next start.
- Start-to-done latency: start sampled at edge 0 puts CLEAR in cycle 1, RUN in cycles 2..3N, and done in cycle 3N+1.
- Edges outside valid data are 0, so a spurious MAC adds 0.
- Arithmetic: none in this block; the counter is wide enough for 3N-2 with no wrap.
- Reset mid-RUN: immediate return to IDLE, all outputs zero. Array contents are undefined until the next CLEAR.

Optional Feature:
- Macro: SYSTOLIC_STALL_EN.
- Defined: adds input stall (1 bit). While stall=1 in RUN:
  - the step counter, skew registers and rd_valid pipeline freeze;
  - array_en=0 and rd_en=0.
  - The operand buffer is assumed to hold read data while stall=1.
  - stall in IDLE, CLEAR or DONE has no effect.
- Undefined: no stall port; RUN always advances every cycle.

Decomposition:
- Package systolic_pkg:
  - state enum {IDLE, CLEAR, RUN, DONE};
  - localparam functions for the last read step (N-1), first enable step (1) and last step (3N-2).
- Sub-module skew_line:
  - parameters DEPTH and WIDTH; DEPTH-stage register chain;
  - DEPTH=0 is a wire; async reset clears all stages; advances on an enable input.
- The controller instantiates 2N skew lines via generate.

Test Plan:
- N=4, A=[[1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16]], B=I, start pulse -> done at cycle 13, busy cycles 1..13, array_en high for exactly 10 cycles, and C=A.
- Skew check, same run -> edge_left lane 2 = A[2][0]=9 at s=3 and A[2][3]=12 at s=6, 0 at all other steps; edge_top lane 3 nonzero only at s=4..7.
- start held high continuously -> runs back-to-back with exactly one IDLE cycle between DONE and the next CLEAR. Repeated pulses during busy are ignored.
- reset asserted at s=5 -> all outputs 0 asynchronously. Next start runs a full clean sequence; all-3s inputs give C entries = 36.
- A,B all 255 (WIDTH=8) -> every C entry = 4*65025 = 260100, which wraps in the 16-bit array accumulator to 63492. Controller timing is unchanged.
- With SYSTOLIC_STALL_EN: stall for 3 cycles at s=4 -> done at cycle 16, C identical to the unstalled run, array_en=0 during stall.
